// File: rtl/control_unit.sv
// Hardwired Mini SRC step sequencer: fetch, decode IR[31:27], and issue per-step
// control strobes, with memory-ready stalls, Stop/halt handling and a retired count.
module control_unit #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [31:0]      IR,
    input  logic             CON_FF,
    input  logic             Mem_Ready,
    input  logic             Stop,
    output logic             Run,
    output logic [CNT_W-1:0] InstrCount,
    output logic             PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout,
    output logic             PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortIn, RAin, Rin,
    output logic             Gra, Grb, Grc, Rout,
    output logic             Read, Write, IncPC,
    output logic [12:0]      AluOp
);

    typedef enum logic [3:0] {
        S_RESET, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_STOPPED
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                           OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                           OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHRA = 5'b01000,
                           OP_SHL  = 5'b01001, OP_ROR  = 5'b01010, OP_ROL  = 5'b01011,
                           OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                           OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001,
                           OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JAL  = 5'b10100,
                           OP_JR   = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                           OP_MFLO = 5'b11000, OP_MFHI = 5'b11001, OP_HALT = 5'b11011;

    state_t           state, last_step, next_t;
    logic [4:0]       opcode;
    logic [CNT_W-1:0] count;
    logic             mem_state, stall, final_step;
    logic             is_alu3, is_imm, is_mem, is_unary, is_muldiv;
    logic [12:0]      alu;
    logic             unused_ir;

    assign unused_ir = ^IR[26:0];

    function automatic logic [12:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST, OP_BR: alu_code = 13'h0004;
            OP_SUB:          alu_code = 13'h0008;
            OP_AND, OP_ANDI: alu_code = 13'h0001;
            OP_OR, OP_ORI:   alu_code = 13'h0002;
            OP_MUL:          alu_code = 13'h0010;
            OP_DIV:          alu_code = 13'h0020;
            OP_SHR:          alu_code = 13'h0040;
            OP_SHRA:         alu_code = 13'h0080;
            OP_SHL:          alu_code = 13'h0100;
            OP_ROR:          alu_code = 13'h0200;
            OP_ROL:          alu_code = 13'h0400;
            OP_NEG:          alu_code = 13'h0800;
            OP_NOT:          alu_code = 13'h1000;
            default:         alu_code = 13'h0000;
        endcase
    endfunction

    assign is_alu3   = (opcode >= OP_ADD) && (opcode <= OP_ROL);
    assign is_imm    = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_mem    = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
    assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign alu       = alu_code(opcode);

    // Instruction length and the memory stall condition, both keyed off the latched opcode.
    always_comb begin
        last_step = S_T3;
        if (opcode == OP_LD)
            last_step = S_T7;
        else if (opcode == OP_ST || opcode == OP_BR || is_muldiv)
            last_step = S_T6;
        else if (is_alu3 || is_imm || opcode == OP_LDI)
            last_step = S_T5;
        else if (is_unary || opcode == OP_JAL)
            last_step = S_T4;

        case (state)
            S_T3:    next_t = S_T4;
            S_T4:    next_t = S_T5;
            S_T5:    next_t = S_T6;
            S_T6:    next_t = S_T7;
            default: next_t = S_F0;
        endcase

        mem_state  = (state == S_F1) || (state == S_T6 && (opcode == OP_LD || opcode == OP_ST));
        stall      = MEM_HANDSHAKE && mem_state && !Mem_Ready;
        final_step = (state == last_step);
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state  <= S_RESET;
            opcode <= '0;
            count  <= '0;
        end else begin
            case (state)
                S_RESET: state <= Stop ? S_STOPPED : S_F0;
                S_F0:    state <= S_F1;
                S_F1:    if (!stall) state <= S_F2;
                S_F2: begin
                    state  <= S_T3;
                    opcode <= IR[31:27];
                end
                S_T3, S_T4, S_T5, S_T6, S_T7: begin
                    if (!stall) begin
                        if (final_step) begin
                            if (count != '1) count <= count + CNT_W'(1);
                            if (opcode == OP_HALT)
                                state <= S_HALT;
                            else if (Stop)
                                state <= S_STOPPED;
                            else
                                state <= S_F0;
                        end else begin
                            state <= next_t;
                        end
                    end
                end
                S_STOPPED: if (!Stop) state <= S_F0;
                default:   state <= state;
            endcase
        end
    end

    assign Run        = (state != S_RESET) && (state != S_HALT) && (state != S_STOPPED);
    assign InstrCount = count;

    always_comb begin
        {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortIn, RAin, Rin} = '0;
        {Gra, Grb, Grc, Rout, Read, Write, IncPC} = '0;
        AluOp = '0;
        case (state)
            S_F0: {PCout, MARin, IncPC, Zin} = '1;
            S_F1: {Zlowout, PCin, Read, MDRin} = '1;
            S_F2: {MDRout, IRin} = '1;
            S_T3: begin
                if (is_alu3 || is_imm) {Grb, Rout, Yin} = '1;
                else if (is_unary) begin
                    {Grb, Rout, Zin} = '1;
                    AluOp = alu;
                end
                else if (is_mem) {Grb, BAout, Yin} = '1;
                else if (is_muldiv) {Gra, Rout, Yin} = '1;
                else begin
                    case (opcode)
                        OP_BR:   {Gra, Rout, CONin} = '1;
                        OP_JR:   {Gra, Rout, PCin} = '1;
                        OP_JAL:  {PCout, RAin, Rin} = '1;
                        OP_MFHI: {Gra, Rin, HIout} = '1;
                        OP_MFLO: {Gra, Rin, LOout} = '1;
                        OP_IN:   {Gra, Rin, InPortout} = '1;
                        OP_OUT:  {Gra, Rout, OutPortIn} = '1;
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                if (is_alu3) begin
                    {Grc, Rout, Zin} = '1;
                    AluOp = alu;
                end else if (is_imm || is_mem) begin
                    {Cout, Zin} = '1;
                    AluOp = alu;
                end else if (is_muldiv) begin
                    {Grb, Rout, Zin} = '1;
                    AluOp = alu;
                end
                else if (is_unary) {Zlowout, Gra, Rin} = '1;
                else if (opcode == OP_BR) {PCout, Yin} = '1;
                else if (opcode == OP_JAL) {Gra, Rout, PCin} = '1;
            end
            S_T5: begin
                if (is_alu3 || is_imm || opcode == OP_LDI) {Zlowout, Gra, Rin} = '1;
                else if (is_mem) {Zlowout, MARin} = '1;
                else if (is_muldiv) {Zlowout, LOin} = '1;
                else if (opcode == OP_BR) begin
                    {Cout, Zin} = '1;
                    AluOp = alu;
                end
            end
            S_T6: begin
                if (opcode == OP_LD) {Read, MDRin} = '1;
                else if (opcode == OP_ST) {Gra, Rout, Write} = '1;
                else if (is_muldiv) {Zhighout, HIin} = '1;
                else if (opcode == OP_BR) begin
                    Zlowout = 1'b1;
                    PCin    = CON_FF;
                end
            end
            S_T7: if (opcode == OP_LD) {MDRout, Gra, Rin} = '1;
            default: ;
        endcase
    end

endmodule
